// File: rtl/axil_reg_pkg.sv
// Shared constants and helpers for the AXI4-Lite register blocks.
// Response codes and index-width helper used by the slave and its byte-lane merge.
package axil_reg_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A single register still gets a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Combinational byte-lane merge: each lane takes new data where its strobe is set,
// otherwise keeps the old value.
module axil_wstrb_merge
  import axil_reg_pkg::*;
(
  input  logic [DATA_W-1:0] old_data,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave holding NUM_REGS 32-bit registers with per-register write pulses.
// Handshakes: a transfer happens on a rising edge where VALID && READY; VALID never waits on READY.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int NUM_REGS           = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]            reg_q,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int IDX_W = idx_width(NUM_REGS);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_reg_slave: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("axil_reg_slave: NUM_REGS must be in 1..16");
  end
  if (C_S_AXI_ADDR_WIDTH < $clog2(NUM_REGS) + 2) begin : g_bad_addr_width
    $error("axil_reg_slave: C_S_AXI_ADDR_WIDTH too small for NUM_REGS");
  end

  logic [IDX_W-1:0] aw_idx, ar_idx;
  if (NUM_REGS > 1) begin : g_idx
    assign aw_idx = S_AXI_AWADDR[IDX_W+1:2];
    assign ar_idx = S_AXI_ARADDR[IDX_W+1:2];
  end else begin : g_idx_single
    assign aw_idx = '0;
    assign ar_idx = '0;
  end

  logic aw_err, ar_err;
  assign aw_err = int'(aw_idx) >= NUM_REGS;
  assign ar_err = int'(ar_idx) >= NUM_REGS;

  logic              aw_held_q, aw_held_d;
  logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
  logic              aw_err_q,  aw_err_d;
  logic              w_held_q,  w_held_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;
  logic              b_valid_q, b_valid_d;
  logic [1:0]        b_resp_q,  b_resp_d;
  logic              r_valid_q, r_valid_d;
  logic [DATA_W-1:0] r_data_q,  r_data_d;
  logic [1:0]        r_resp_q,  r_resp_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              aw_hs, w_hs, ar_hs, commit;
  logic [DATA_W-1:0] old_data, merged;
  logic [NUM_REGS-1:0] wr_pulse;

  assign aw_hs  = S_AXI_AWVALID && !aw_held_q;
  assign w_hs   = S_AXI_WVALID && !w_held_q;
  assign ar_hs  = S_AXI_ARVALID && !r_valid_q;
  // A commit needs the B channel free, or freeing on this very edge.
  assign commit = aw_held_q && w_held_q && (!b_valid_q || S_AXI_BREADY);

  assign old_data = aw_err_q ? '0 : regs_q[aw_idx_q];

  axil_wstrb_merge u_merge (
    .old_data (old_data),
    .wdata    (w_data_q),
    .wstrb    (w_strb_q),
    .merged   (merged)
  );

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    regs_d    = regs_q;
    wr_pulse  = '0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = aw_err_q ? RESP_SLVERR : RESP_OKAY;
      if (!aw_err_q) begin
        regs_d[aw_idx_q]   = merged;
        wr_pulse[aw_idx_q] = 1'b1;
      end
    end else if (b_valid_q && S_AXI_BREADY) begin
      b_valid_d = 1'b0;
    end

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = aw_idx;
      aw_err_d  = aw_err;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    // Reads sample regs_q, so a same-cycle commit is not yet visible.
    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_resp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
      r_data_d  = ar_err ? '0 : regs_q[ar_idx];
    end else if (r_valid_q && S_AXI_RREADY) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      regs_q    <= '{default: '0};
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AXI_AWREADY = !aw_held_q;
  assign S_AXI_WREADY  = !w_held_q;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_BRESP   = b_resp_q;
  assign S_AXI_ARREADY = !r_valid_q;
  assign S_AXI_RVALID  = r_valid_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = r_resp_q;
  assign reg_wr_pulse  = wr_pulse;

  always_comb begin
    reg_q = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_q[32*k +: 32] = regs_q[k];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule
